rv_mc_ctrl: RTL and testbench

Multicycle control unit for the polirv RV64I core. Sequences one instruction at a time through IDLE/FETCH/DECODE/EXEC/MEM/WB, handshakes with the instruction and data memories, and drives the datapath control lines: IR/PC/register-file write enables, ALU command, operand and writeback selects. It replaces the combinational UC and sits between the memories and DataFlow, consuming the opcode, funct and flag fields that DataFlow returns.

---
 rtl/rv_mc_ctrl_pkg.sv | 88 ++++++++
 rtl/rv_mc_ctrl_if.sv | 40 ++++
 rtl/rv_mc_ctrl_branch_cond.sv | 34 +++
 rtl/rv_mc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_mc_ctrl_pkg.sv
// Shared types and encodings for the polirv multicycle control unit:
// FSM states, instruction classes, opcodes, ALU commands and mux selects.
package rv_mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CLS_NONE   = 4'd0,
      CLS_LOAD   = 4'd1,
      CLS_STORE  = 4'd2,
      CLS_OP     = 4'd3,
      CLS_OPIMM  = 4'd4,
      CLS_BRANCH = 4'd5,
      CLS_JAL    = 4'd6,
      CLS_JALR   = 4'd7,
      CLS_LUI    = 4'd8,
      CLS_AUIPC  = 4'd9
   } class_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
   localparam logic [1:0] PC_SRC_IMM   = 2'd1;
   localparam logic [1:0] PC_SRC_ALU   = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   function automatic class_t classify(input logic [6:0] opc);
      class_t cls;
      case (opc)
         OPC_LOAD:   cls = CLS_LOAD;
         OPC_STORE:  cls = CLS_STORE;
         OPC_OP:     cls = CLS_OP;
         OPC_OPIMM:  cls = CLS_OPIMM;
         OPC_BRANCH: cls = CLS_BRANCH;
         OPC_JAL:    cls = CLS_JAL;
         OPC_JALR:   cls = CLS_JALR;
         OPC_LUI:    cls = CLS_LUI;
         OPC_AUIPC:  cls = CLS_AUIPC;
         default:    cls = CLS_NONE;
      endcase
      return cls;
   endfunction

   // Only funct7[5] matters: it selects SUB over ADD and SRA over SRL.
   function automatic logic [3:0] alu_cmd_for(input class_t cls, input logic [2:0] f3,
                                              input logic f7_5);
      logic [3:0] cmd;
      case (cls)
         CLS_OP:     cmd = {f7_5, f3};
         CLS_OPIMM:  cmd = {f7_5 & (f3 == 3'b101), f3};
         CLS_BRANCH: cmd = ALU_SUB;
         default:    cmd = ALU_ADD;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/rv_mc_ctrl_if.sv
// Memory handshake, IR field and datapath control bundle between the control
// unit (master) and DataFlow plus the memories (slave).
interface rv_mc_ctrl_if;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [3:0]  alu_flags;
   logic        i_mem_ready;
   logic        d_mem_ready;

   logic        i_mem_req;
   logic        d_mem_req;
   logic        d_mem_we;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        rf_we;
   logic        alu_src;
   logic        alu_a_pc;
   logic [3:0]  alu_cmd;
   logic [1:0]  wb_sel;
   logic        trap;
   logic [63:0] instret;

   // A request is held high until the matching ready is seen in the same cycle;
   // a ready outside its request window is ignored.
   modport master (
      input  opcode, funct3, funct7, alu_flags, i_mem_ready, d_mem_ready,
      output i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, pc_src, rf_we,
             alu_src, alu_a_pc, alu_cmd, wb_sel, trap, instret
   );

   modport slave (
      output opcode, funct3, funct7, alu_flags, i_mem_ready, d_mem_ready,
      input  i_mem_req, d_mem_req, d_mem_we, ir_we, pc_we, pc_src, rf_we,
             alu_src, alu_a_pc, alu_cmd, wb_sel, trap, instret
   );

endinterface

// File: rtl/rv_mc_ctrl_branch_cond.sv
// Branch resolution from funct3 and the {N,Z,C,V} flags of rs1 - rs2.
// C=1 means no borrow, so unsigned rs1 >= rs2.
module rv_mc_ctrl_branch_cond (
   input  logic [2:0] i_funct3,
   input  logic [3:0] i_alu_flags,
   output logic       o_taken,
   output logic       o_illegal
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = i_alu_flags[3];
   assign w_z = i_alu_flags[2];
   assign w_c = i_alu_flags[1];
   assign w_v = i_alu_flags[0];

   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_funct3)
         3'b000:  o_taken = w_z;
         3'b001:  o_taken = ~w_z;
         3'b100:  o_taken = w_n ^ w_v;
         3'b101:  o_taken = ~(w_n ^ w_v);
         3'b110:  o_taken = ~w_c;
         3'b111:  o_taken = w_c;
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multicycle control unit: sequences one instruction at a time through
// FETCH/DECODE/EXEC/MEM/WB and drives the DataFlow control lines.
module rv_mc_ctrl
   import rv_mc_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   rv_mc_ctrl_if.master      bus,
   output state_t            o_dbg_state
);

   state_t      r_state;
   class_t      r_class;
   logic [3:0]  r_alu_cmd;
   logic [63:0] r_instret;

   class_t      w_class;
   logic        w_taken;
   logic        w_br_illegal;
   logic        w_decode_trap;

   logic        w_i_mem_req;
   logic        w_d_mem_req;
   logic        w_d_mem_we;
   logic        w_ir_we;
   logic        w_pc_we;
   logic [1:0]  w_pc_src;
   logic        w_rf_we;
   logic        w_alu_src;
   logic        w_alu_a_pc;
   logic [1:0]  w_wb_sel;
   logic        w_trap;

   rv_mc_ctrl_branch_cond u_branch_cond (
      .i_funct3    (bus.funct3),
      .i_alu_flags (bus.alu_flags),
      .o_taken     (w_taken),
      .o_illegal   (w_br_illegal)
   );

   assign w_class       = classify(bus.opcode);
   assign w_decode_trap = (w_class == CLS_NONE) ||
                          ((w_class == CLS_BRANCH) && w_br_illegal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_class   <= CLS_NONE;
         r_alu_cmd <= ALU_ADD;
      end else begin
         case (r_state)
            ST_IDLE: r_state <= ST_FETCH;
            ST_FETCH: begin
               if (bus.i_mem_ready) r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_class   <= w_class;
               r_alu_cmd <= alu_cmd_for(w_class, bus.funct3, bus.funct7[5]);
               r_state   <= w_decode_trap ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
               case (r_class)
                  CLS_LOAD, CLS_STORE:                   r_state <= ST_MEM;
                  CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC: r_state <= ST_WB;
                  default:                               r_state <= ST_FETCH;
               endcase
            end
            ST_MEM: begin
               if (bus.d_mem_ready) r_state <= (r_class == CLS_LOAD) ? ST_WB : ST_FETCH;
            end
            ST_WB:   r_state <= ST_FETCH;
            ST_TRAP: r_state <= ST_TRAP;
            default: r_state <= ST_TRAP;
         endcase
      end
   end

   // Everything decodes from the state register and latched class; the only
   // input-dependent terms are the memory readies and the branch outcome.
   always_comb begin
      w_i_mem_req = 1'b0;
      w_d_mem_req = 1'b0;
      w_d_mem_we  = 1'b0;
      w_ir_we     = 1'b0;
      w_pc_we     = 1'b0;
      w_pc_src    = PC_SRC_PLUS4;
      w_rf_we     = 1'b0;
      w_wb_sel    = WB_ALU;
      w_trap      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_i_mem_req = 1'b1;
            w_ir_we     = bus.i_mem_ready;
         end
         ST_EXEC: begin
            case (r_class)
               CLS_BRANCH: begin
                  w_pc_we  = 1'b1;
                  w_pc_src = w_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
               end
               CLS_JAL: begin
                  w_pc_we  = 1'b1;
                  w_pc_src = PC_SRC_IMM;
                  w_rf_we  = 1'b1;
                  w_wb_sel = WB_PC4;
               end
               CLS_JALR: begin
                  w_pc_we  = 1'b1;
                  w_pc_src = PC_SRC_ALU;
                  w_rf_we  = 1'b1;
                  w_wb_sel = WB_PC4;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            w_d_mem_req = 1'b1;
            w_d_mem_we  = (r_class == CLS_STORE);
            w_pc_we     = (r_class == CLS_STORE) && bus.d_mem_ready;
         end
         ST_WB: begin
            w_pc_we = 1'b1;
            w_rf_we = 1'b1;
            case (r_class)
               CLS_LOAD: w_wb_sel = WB_MEM;
               CLS_LUI:  w_wb_sel = WB_IMM;
               default:  w_wb_sel = WB_ALU;
            endcase
         end
         ST_TRAP: w_trap = 1'b1;
         default: ;
      endcase
   end

   // Operand selects only apply once the class has been latched.
   always_comb begin
      w_alu_src  = 1'b0;
      w_alu_a_pc = 1'b0;
      if ((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB)) begin
         w_alu_src  = (r_class == CLS_OPIMM) || (r_class == CLS_LOAD) ||
                      (r_class == CLS_STORE) || (r_class == CLS_JALR);
         w_alu_a_pc = (r_class == CLS_AUIPC);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instret <= 64'd0;
      end else if (w_pc_we) begin
         r_instret <= r_instret + 64'd1;
      end
   end

   assign bus.i_mem_req = w_i_mem_req;
   assign bus.d_mem_req = w_d_mem_req;
   assign bus.d_mem_we  = w_d_mem_we;
   assign bus.ir_we     = w_ir_we;
   assign bus.pc_we     = w_pc_we;
   assign bus.pc_src    = w_pc_src;
   assign bus.rf_we     = w_rf_we;
   assign bus.alu_src   = w_alu_src;
   assign bus.alu_a_pc  = w_alu_a_pc;
   assign bus.alu_cmd   = r_alu_cmd;
   assign bus.wb_sel    = w_wb_sel;
   assign bus.trap      = w_trap;
   assign bus.instret   = r_instret;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl: directed cases plus randomized
// instruction streams against a per-instruction behavioural model.
module tb_rv_mc_ctrl;
   import rv_mc_ctrl_pkg::*;

   localparam int K_LOAD   = 0;
   localparam int K_STORE  = 1;
   localparam int K_OP     = 2;
   localparam int K_OPIMM  = 3;
   localparam int K_BRANCH = 4;
   localparam int K_JAL    = 5;
   localparam int K_JALR   = 6;
   localparam int K_LUI    = 7;
   localparam int K_AUIPC  = 8;
   localparam int K_ILL    = 9;

   logic        clk;
   logic        rst_n;
   state_t      dbg_state;
   rv_mc_ctrl_if bus ();

   int          n_checks;
   int          n_errors;
   logic [63:0] exp_q[$];
   logic [63:0] instret_m;

   rv_mc_ctrl u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_instret_q();
      logic [63:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("instret", bus.instret, e);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b0110011: return K_OP;
         7'b0010011: return K_OPIMM;
         7'b1100011: return K_BRANCH;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0110111: return K_LUI;
         7'b0010111: return K_AUIPC;
         default:    return K_ILL;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("idle_cycle_i_mem_req", bus.i_mem_req, 1'b0);
      check_eq("idle_cycle_state", dbg_state, ST_IDLE);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      bus.i_mem_ready = 1'b1;
      bus.d_mem_ready = 1'b1;
      #1;
      check_eq("rst_outputs",
               {bus.i_mem_req, bus.d_mem_req, bus.d_mem_we, bus.ir_we, bus.pc_we, bus.pc_src,
                bus.rf_we, bus.alu_src, bus.alu_a_pc, bus.alu_cmd, bus.wb_sel, bus.trap}, 0);
      check_eq("rst_instret", bus.instret, 0);
      check_eq("rst_state", dbg_state, ST_IDLE);
      repeat (2) @(negedge clk);
      instret_m = 64'd0;
      exp_q.delete();
      release_reset();
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int iw, input int dw, input logic [63:0] a, input logic [63:0] b);
      int          k;
      bit          legal;
      bit          is_mem;
      bit          taken;
      bit          cmd_known;
      int          exp_len;
      int          e_rf;
      int          e_dreq;
      int          e_dwe;
      logic [1:0]  e_src;
      logic [1:0]  e_wb;
      logic [3:0]  e_cmd;
      logic        e_asrc;
      logic        e_apc;
      logic [63:0] diff;
      int          cyc;
      int          max_cyc;
      bit          done;
      int          n_ireq, n_irwe, n_dreq, n_dwe, n_pcwe, n_rfwe, n_en;
      int          pc_idx, trap_idx;
      logic [1:0]  got_src, got_wb;
      logic [3:0]  got_cmd;
      logic        got_asrc, got_apc;
      bit          tr_held;

      k      = kind_of(op);
      legal  = (k != K_ILL) && !((k == K_BRANCH) && ((f3 == 3'b010) || (f3 == 3'b011)));
      is_mem = (k == K_LOAD) || (k == K_STORE);
      diff   = a - b;
      case (f3)
         3'b000:  taken = (a == b);
         3'b001:  taken = (a != b);
         3'b100:  taken = ($signed(a) <  $signed(b));
         3'b101:  taken = ($signed(a) >= $signed(b));
         3'b110:  taken = (a <  b);
         3'b111:  taken = (a >= b);
         default: taken = 1'b0;
      endcase

      case (k)
         K_BRANCH, K_JAL, K_JALR: exp_len = iw + 3;
         K_STORE:                 exp_len = iw + dw + 4;
         K_LOAD:                  exp_len = iw + dw + 5;
         default:                 exp_len = iw + 4;
      endcase
      e_src  = (k == K_BRANCH) ? (taken ? 2'd1 : 2'd0) : (k == K_JAL) ? 2'd1 :
               (k == K_JALR) ? 2'd2 : 2'd0;
      e_wb   = (k == K_LOAD) ? 2'd1 : ((k == K_JAL) || (k == K_JALR)) ? 2'd2 :
               (k == K_LUI) ? 2'd3 : 2'd0;
      e_rf   = ((k == K_STORE) || (k == K_BRANCH)) ? 0 : 1;
      e_dreq = is_mem ? dw + 1 : 0;
      e_dwe  = (k == K_STORE) ? dw + 1 : 0;
      cmd_known = 1'b1;
      case (k)
         K_OP:     e_cmd = 4'((f7[5] ? 8 : 0) + f3);
         K_OPIMM:  e_cmd = 4'(((f3 == 3'd5) && f7[5] ? 8 : 0) + f3);
         K_BRANCH: e_cmd = 4'd8;
         K_LOAD, K_STORE, K_AUIPC, K_JALR: e_cmd = 4'd0;
         default: begin
            e_cmd     = 4'd0;
            cmd_known = 1'b0;
         end
      endcase
      e_asrc = (k == K_OPIMM) || (k == K_LOAD) || (k == K_STORE) || (k == K_JALR);
      e_apc  = (k == K_AUIPC);

      bus.opcode    = op;
      bus.funct3    = f3;
      bus.funct7    = f7;
      bus.alu_flags = {diff[63], (diff == 64'd0), (a >= b),
                       ((a[63] != b[63]) && (diff[63] != a[63]))};

      cyc = 0; done = 1'b0; pc_idx = -1; trap_idx = -1;
      n_ireq = 0; n_irwe = 0; n_dreq = 0; n_dwe = 0; n_pcwe = 0; n_rfwe = 0;
      got_src = 2'd0; got_wb = 2'd0; got_cmd = 4'd0; got_asrc = 1'b0; got_apc = 1'b0;
      max_cyc = legal ? exp_len + 4 : iw + 6;
      while (!done && (cyc < max_cyc)) begin
         @(negedge clk);
         bus.i_mem_ready = (cyc < iw) ? 1'b0 : (cyc == iw) ? 1'b1 : 1'($urandom_range(0, 1));
         if (is_mem && (cyc >= iw + 3)) bus.d_mem_ready = (cyc >= iw + 3 + dw);
         else                           bus.d_mem_ready = 1'($urandom_range(0, 1));
         #1;
         if (cyc == 0) check_instret_q();
         n_ireq += int'(bus.i_mem_req);
         n_irwe += int'(bus.ir_we);
         n_dreq += int'(bus.d_mem_req);
         n_dwe  += int'(bus.d_mem_we);
         if (cyc == iw + 2) begin
            got_cmd  = bus.alu_cmd;
            got_asrc = bus.alu_src;
            got_apc  = bus.alu_a_pc;
         end
         if (bus.rf_we) begin
            n_rfwe++;
            got_wb = bus.wb_sel;
         end
         if (bus.pc_we) begin
            n_pcwe++;
            if (pc_idx < 0) begin
               pc_idx  = cyc;
               got_src = bus.pc_src;
            end
         end
         if (bus.trap && (trap_idx < 0)) trap_idx = cyc;
         done = bus.pc_we || bus.trap;
         cyc++;
      end
      check_eq("finished_in_budget", done, 1'b1);
      check_eq("i_mem_req_cycles", n_ireq, iw + 1);

      if (legal) begin
         check_eq("retire_cycle", pc_idx, exp_len - 1);
         check_eq("pc_we_count", n_pcwe, 1);
         check_eq("pc_src", got_src, e_src);
         check_eq("rf_we_count", n_rfwe, e_rf);
         if (e_rf != 0) check_eq("wb_sel", got_wb, e_wb);
         check_eq("ir_we_count", n_irwe, 1);
         check_eq("d_mem_req_cycles", n_dreq, e_dreq);
         check_eq("d_mem_we_cycles", n_dwe, e_dwe);
         if (cmd_known) check_eq("alu_cmd", got_cmd, e_cmd);
         check_eq("alu_src", got_asrc, e_asrc);
         check_eq("alu_a_pc", got_apc, e_apc);
         check_eq("no_trap", trap_idx, -1);
         instret_m = instret_m + 64'd1;
         exp_q.push_back(instret_m);
      end else begin
         check_eq("trap_cycle", trap_idx, iw + 2);
         check_eq("trap_no_pc_we", n_pcwe, 0);
         check_eq("trap_no_rf_we", n_rfwe, 0);
         n_ireq = 0; n_pcwe = 0; n_en = 0; tr_held = 1'b1;
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.i_mem_ready = 1'b1;
            bus.d_mem_ready = 1'b1;
            #1;
            n_ireq += int'(bus.i_mem_req);
            n_pcwe += int'(bus.pc_we);
            n_en   += int'(bus.rf_we | bus.ir_we | bus.d_mem_req | bus.d_mem_we);
            if (!bus.trap) tr_held = 1'b0;
         end
         check_eq("trap_held", tr_held, 1'b1);
         check_eq("trap_i_mem_req", n_ireq, 0);
         check_eq("trap_pc_we", n_pcwe, 0);
         check_eq("trap_enables", n_en, 0);
         do_reset();
      end
   endtask

   // Store held in MEM by a slow memory, then reset dropped between clock edges.
   task automatic store_reset_test();
      bus.opcode = 7'b0100011;
      bus.funct3 = 3'b011;
      bus.funct7 = 7'd0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.i_mem_ready = (c == 0);
         bus.d_mem_ready = 1'b0;
         #1;
         if (c == 0) check_instret_q();
      end
      check_eq("sd_mem_we_before_reset", bus.d_mem_we, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("sd_mem_we_async_drop", bus.d_mem_we, 1'b0);
      check_eq("sd_mem_req_async_drop", bus.d_mem_req, 1'b0);
      check_eq("sd_reset_state", dbg_state, ST_IDLE);
      check_eq("sd_reset_instret", bus.instret, 0);
      instret_m = 64'd0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      release_reset();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [6:0]  legal_ops [9];
      logic [6:0]  ill_ops [4];
      logic [6:0]  op;
      logic [63:0] a, b;
      legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                    7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
      ill_ops   = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};
      n_checks  = 0;
      n_errors  = 0;
      instret_m = 64'd0;
      rst_n     = 1'b0;
      bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.alu_flags = 4'd0;
      bus.i_mem_ready = 1'b0; bus.d_mem_ready = 1'b0;

      do_reset();
      // ADD x3, x1, x2 (0x002081B3)
      run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 64'd7, 64'd9);
      run_instr(7'b1100011, 3'b000, 7'd0, 0, 0, 64'd5, 64'd5);
      run_instr(7'b1100011, 3'b000, 7'd0, 0, 0, 64'd5, 64'd6);
      run_instr(7'b0000011, 3'b010, 7'd0, 0, 3, 64'd1, 64'd2);
      run_instr(7'b0010011, 3'b101, 7'b0100000, 0, 0, 64'd1, 64'd2);
      run_instr(7'b0010011, 3'b101, 7'b0000000, 1, 0, 64'd1, 64'd2);
      run_instr(7'b0010011, 3'b000, 7'b0100000, 0, 0, 64'd1, 64'd2);
      run_instr(7'b1100011, 3'b110, 7'd0, 2, 0, 64'hffff_ffff_ffff_fff0, 64'd3);
      run_instr(7'b1100011, 3'b100, 7'd0, 0, 0, 64'hffff_ffff_ffff_fff0, 64'd3);
      store_reset_test();
      run_instr(7'b0110111, 3'b000, 7'd0, 0, 0, 64'd0, 64'd0);
      run_instr(7'b0000000, 3'b000, 7'd0, 0, 0, 64'd0, 64'd0);

      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 19) < 18) op = legal_ops[$urandom_range(0, 8)];
         else                            op = ill_ops[$urandom_range(0, 3)];
         a = {$urandom(), $urandom()};
         b = ($urandom_range(0, 3) == 0) ? a : {$urandom(), $urandom()};
         run_instr(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), a, b);
      end

      @(negedge clk);
      bus.i_mem_ready = 1'b0;
      #1;
      check_instret_q();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
